// File: rtl/ac97_pcm_dma.sv
// Single-channel playback DMA: on each controller request, reads a burst of PCM words
// from memory over one WISHBONE master and writes them to an AC97 FIFO over another.
module ac97_pcm_dma #(
   parameter int          BURST  = 4,
   parameter logic [31:0] AC_ADR = 32'h0000_0020
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        cfg_start,
   input  logic        cfg_abort,
   input  logic [31:0] cfg_base,
   input  logic [15:0] cfg_len,
   input  logic        cfg_loop,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   input  logic        dma_req_i,
   output logic        dma_ack_o,
   output logic [31:0] mem_adr_o,
   output logic        mem_cyc_o,
   output logic        mem_stb_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_sel_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i,
   input  logic        mem_err_i,
   output logic [31:0] ac_adr_o,
   output logic [31:0] ac_data_o,
   output logic        ac_cyc_o,
   output logic        ac_stb_o,
   output logic        ac_we_o,
   output logic [3:0]  ac_sel_o,
   input  logic        ac_ack_i,
   input  logic        ac_err_i
);

   localparam int IW = (BURST > 1) ? $clog2(BURST) : 1;
   localparam logic [IW:0] BURST_W = (IW+1)'(BURST);
   localparam logic [IW:0] ONE_W   = (IW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_REQ = 3'd1,
      S_RD       = 3'd2,
      S_WR       = 3'd3,
      S_ACK      = 3'd4,
      S_HOLD     = 3'd5,
      S_ERR      = 3'd6
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_base, w_base_nxt;
   logic [15:0] r_len, w_len_nxt;
   logic        r_loop, w_loop_nxt;
   logic [31:0] r_adr, w_adr_nxt;
   logic [15:0] r_left, w_left_nxt;
   logic [IW:0] r_n, w_n_nxt;
   logic [IW:0] r_cnt, w_cnt_nxt;
   logic        r_hold, w_hold_nxt;
   logic        r_mem_cyc, w_mem_cyc_nxt;
   logic        r_ac_cyc, w_ac_cyc_nxt;
   logic        r_dma_ack, w_dma_ack_nxt;
   logic        r_done, w_done_nxt;
   logic        r_err, w_err_nxt;
   logic        r_busy, w_busy_nxt;
   logic        w_buf_we;
   logic [31:0] r_buf [0:BURST-1];

   // Next-state and next-output computation; abort overrides every other event.
   always_comb begin
      w_state_nxt   = r_state;
      w_base_nxt    = r_base;
      w_len_nxt     = r_len;
      w_loop_nxt    = r_loop;
      w_adr_nxt     = r_adr;
      w_left_nxt    = r_left;
      w_n_nxt       = r_n;
      w_cnt_nxt     = r_cnt;
      w_hold_nxt    = r_hold;
      w_mem_cyc_nxt = r_mem_cyc;
      w_ac_cyc_nxt  = r_ac_cyc;
      w_dma_ack_nxt = 1'b0;
      w_done_nxt    = 1'b0;
      w_err_nxt     = r_err;
      w_busy_nxt    = r_busy;
      w_buf_we      = 1'b0;
      if (cfg_abort) begin
         w_state_nxt   = S_IDLE;
         w_mem_cyc_nxt = 1'b0;
         w_ac_cyc_nxt  = 1'b0;
         w_busy_nxt    = 1'b0;
         w_err_nxt     = 1'b0;
         w_cnt_nxt     = '0;
         w_n_nxt       = '0;
         w_hold_nxt    = 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_ERR: begin
               if (cfg_start) begin
                  w_base_nxt = {cfg_base[31:2], 2'b00};
                  w_len_nxt  = cfg_len;
                  w_loop_nxt = cfg_loop;
                  w_adr_nxt  = {cfg_base[31:2], 2'b00};
                  w_left_nxt = cfg_len;
                  w_cnt_nxt  = '0;
                  w_err_nxt  = 1'b0;
                  if (cfg_len == 16'd0) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = S_IDLE;
                     w_busy_nxt  = 1'b0;
                  end else begin
                     w_state_nxt = S_WAIT_REQ;
                     w_busy_nxt  = 1'b1;
                  end
               end else begin
                  w_state_nxt = r_state;
               end
            end
            S_WAIT_REQ: begin
               if (dma_req_i) begin
                  if (r_left >= 16'(BURST)) begin
                     w_n_nxt = BURST_W;
                  end else begin
                     w_n_nxt = r_left[IW:0];
                  end
                  w_cnt_nxt     = '0;
                  w_mem_cyc_nxt = 1'b1;
                  w_state_nxt   = S_RD;
               end else begin
                  w_state_nxt = S_WAIT_REQ;
               end
            end
            S_RD: begin
               if (mem_err_i) begin
                  w_mem_cyc_nxt = 1'b0;
                  w_err_nxt     = 1'b1;
                  w_busy_nxt    = 1'b0;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = S_ERR;
               end else if (mem_ack_i) begin
                  w_buf_we  = 1'b1;
                  w_adr_nxt = r_adr + 32'd4;
                  if (r_cnt == r_n - ONE_W) begin
                     w_cnt_nxt     = '0;
                     w_mem_cyc_nxt = 1'b0;
                     w_ac_cyc_nxt  = 1'b1;
                     w_state_nxt   = S_WR;
                  end else begin
                     w_cnt_nxt = r_cnt + ONE_W;
                  end
               end else begin
                  w_state_nxt = S_RD;
               end
            end
            S_WR: begin
               if (ac_err_i) begin
                  w_ac_cyc_nxt = 1'b0;
                  w_err_nxt    = 1'b1;
                  w_busy_nxt   = 1'b0;
                  w_cnt_nxt    = '0;
                  w_state_nxt  = S_ERR;
               end else if (ac_ack_i) begin
                  if (r_cnt == r_n - ONE_W) begin
                     w_cnt_nxt     = '0;
                     w_ac_cyc_nxt  = 1'b0;
                     w_dma_ack_nxt = 1'b1;
                     w_left_nxt    = r_left - 16'(r_n);
                     w_done_nxt    = (r_left == 16'(r_n));
                     w_state_nxt   = S_ACK;
                  end else begin
                     w_cnt_nxt = r_cnt + ONE_W;
                  end
               end else begin
                  w_state_nxt = S_WR;
               end
            end
            S_ACK: begin
               w_hold_nxt  = 1'b0;
               w_state_nxt = S_HOLD;
               if ((r_left == 16'd0) && r_loop) begin
                  w_adr_nxt  = r_base;
                  w_left_nxt = r_len;
               end else begin
                  w_adr_nxt = r_adr;
               end
            end
            S_HOLD: begin
               // Two-cycle hold gives the controller time to drop its stale request.
               if (r_hold) begin
                  w_hold_nxt = 1'b0;
                  if (r_left != 16'd0) begin
                     w_state_nxt = S_WAIT_REQ;
                  end else begin
                     w_state_nxt = S_IDLE;
                     w_busy_nxt  = 1'b0;
                  end
               end else begin
                  w_hold_nxt = 1'b1;
               end
            end
            default: begin
               w_state_nxt   = S_IDLE;
               w_mem_cyc_nxt = 1'b0;
               w_ac_cyc_nxt  = 1'b0;
               w_busy_nxt    = 1'b0;
            end
         endcase
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and registered bus/status outputs.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         r_base    <= 32'd0;
         r_len     <= 16'd0;
         r_loop    <= 1'b0;
         r_adr     <= 32'd0;
         r_left    <= 16'd0;
         r_n       <= '0;
         r_cnt     <= '0;
         r_hold    <= 1'b0;
         r_mem_cyc <= 1'b0;
         r_ac_cyc  <= 1'b0;
         r_dma_ack <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_base    <= w_base_nxt;
         r_len     <= w_len_nxt;
         r_loop    <= w_loop_nxt;
         r_adr     <= w_adr_nxt;
         r_left    <= w_left_nxt;
         r_n       <= w_n_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hold    <= w_hold_nxt;
         r_mem_cyc <= w_mem_cyc_nxt;
         r_ac_cyc  <= w_ac_cyc_nxt;
         r_dma_ack <= w_dma_ack_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   // Burst buffer, filled in memory order during reads.
   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < BURST; i++) begin
            r_buf[i] <= 32'd0;
         end
      end else if (w_buf_we) begin
         r_buf[r_cnt[IW-1:0]] <= mem_data_i;
      end
   end

   assign busy_o    = r_busy;
   assign done_o    = r_done;
   assign err_o     = r_err;
   assign dma_ack_o = r_dma_ack;
   assign mem_adr_o = r_adr;
   assign mem_cyc_o = r_mem_cyc;
   assign mem_stb_o = r_mem_cyc;
   assign mem_we_o  = 1'b0;
   assign mem_sel_o = 4'hf;
   assign ac_adr_o  = AC_ADR;
   assign ac_data_o = r_buf[r_cnt[IW-1:0]];
   assign ac_cyc_o  = r_ac_cyc;
   assign ac_stb_o  = r_ac_cyc;
   assign ac_we_o   = r_ac_cyc;
   assign ac_sel_o  = 4'hf;

endmodule

// File: tb/tb_ac97_pcm_dma.sv
// Directed bench for ac97_pcm_dma: table of transfers against memory/FIFO slave models,
// plus hand sequences for loop, abort, async reset and start-while-busy.
module tb_ac97_pcm_dma;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        cfg_start, cfg_abort, cfg_loop;
   logic [31:0] cfg_base;
   logic [15:0] cfg_len;
   logic        busy_o, done_o, err_o;
   logic        dma_req_i, dma_ack_o;
   logic [31:0] mem_adr_o, mem_data_i;
   logic        mem_cyc_o, mem_stb_o, mem_we_o, mem_ack_i, mem_err_i;
   logic [3:0]  mem_sel_o, ac_sel_o;
   logic [31:0] ac_adr_o, ac_data_o;
   logic        ac_cyc_o, ac_stb_o, ac_we_o, ac_ack_i, ac_err_i;

   ac97_pcm_dma #(.BURST(4), .AC_ADR(32'h0000_0020)) dut (
      .clk(clk), .rst_i(rst_i),
      .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_base(cfg_base),
      .cfg_len(cfg_len), .cfg_loop(cfg_loop),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
      .dma_req_i(dma_req_i), .dma_ack_o(dma_ack_o),
      .mem_adr_o(mem_adr_o), .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
      .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_data_i(mem_data_i),
      .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i),
      .ac_adr_o(ac_adr_o), .ac_data_o(ac_data_o), .ac_cyc_o(ac_cyc_o),
      .ac_stb_o(ac_stb_o), .ac_we_o(ac_we_o), .ac_sel_o(ac_sel_o),
      .ac_ack_i(ac_ack_i), .ac_err_i(ac_err_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic [15:0] len;
      int          rdw, wrw, merr, aerr;
      int          exp_words, exp_acks, exp_done;
      logic [31:0] exp_adr;
      logic        exp_err;
   } vec_t;

   vec_t        vt [8];
   int          n_chk = 0, n_fail = 0;
   int          rd_wmax, wr_wmax, mem_err_beat, ac_err_beat;
   int          mw, aw, mbeat, abeat;
   int          ack_cnt, done_cnt, bad_attr;
   logic [31:0] got_q [$];

   function automatic logic [31:0] model(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory read slave with programmable wait states and error injection.
   initial begin
      mem_ack_i = 1'b0; mem_err_i = 1'b0; mem_data_i = 32'd0;
      forever begin
         @(negedge clk);
         mem_ack_i = 1'b0; mem_err_i = 1'b0;
         if (mem_stb_o && !rst_i) begin
            if (mw > 0) mw--;
            else begin
               if (mbeat == mem_err_beat) mem_err_i = 1'b1;
               else begin
                  mem_ack_i  = 1'b1;
                  mem_data_i = model(mem_adr_o);
               end
               mbeat++;
               mw = $urandom_range(rd_wmax, 0);
            end
         end
      end
   end

   // FIFO write slave: records accepted words and bus attributes.
   initial begin
      ac_ack_i = 1'b0; ac_err_i = 1'b0;
      forever begin
         @(negedge clk);
         ac_ack_i = 1'b0; ac_err_i = 1'b0;
         if (ac_stb_o && !rst_i) begin
            if (aw > 0) aw--;
            else begin
               if (abeat == ac_err_beat) ac_err_i = 1'b1;
               else begin
                  ac_ack_i = 1'b1;
                  got_q.push_back(ac_data_o);
                  if (ac_adr_o !== 32'h20 || ac_we_o !== 1'b1 || ac_sel_o !== 4'hf || !ac_cyc_o)
                     bad_attr++;
               end
               abeat++;
               aw = $urandom_range(wr_wmax, 0);
            end
         end
      end
   end

   initial begin
      ack_cnt = 0; done_cnt = 0;
      forever begin
         @(negedge clk);
         if (dma_ack_o) ack_cnt++;
         if (done_o) done_cnt++;
      end
   end

   task automatic clr(input int rw, input int ww, input int me, input int ae);
      rd_wmax = rw; wr_wmax = ww; mem_err_beat = me; ac_err_beat = ae;
      mw = 0; aw = 0; mbeat = 0; abeat = 0;
      got_q.delete(); ack_cnt = 0; done_cnt = 0; bad_attr = 0;
   endtask

   task automatic start_xfer(input logic [31:0] b, input logic [15:0] l, input logic lp);
      @(negedge clk);
      cfg_base = b; cfg_len = l; cfg_loop = lp; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
   endtask

   task automatic run(input int idx);
      int k;
      vec_t v;
      logic [31:0] ab;
      v = vt[idx];
      clr(v.rdw, v.wrw, v.merr, v.aerr);
      start_xfer(v.base, v.len, 1'b0);
      k = 0;
      while (k < 4000 && (busy_o || k < 4)) begin
         @(negedge clk);
         k++;
      end
      if (k >= 4000) chk($sformatf("v%0d_timeout", idx), 32'd1, 32'd0);
      chk($sformatf("v%0d_err", idx), {31'd0, err_o}, {31'd0, v.exp_err});
      chk($sformatf("v%0d_acks", idx), ack_cnt, v.exp_acks);
      chk($sformatf("v%0d_done", idx), done_cnt, v.exp_done);
      chk($sformatf("v%0d_adr", idx), mem_adr_o, v.exp_adr);
      chk($sformatf("v%0d_nwords", idx), got_q.size(), v.exp_words);
      chk($sformatf("v%0d_acattr", idx), bad_attr, 32'd0);
      ab = {v.base[31:2], 2'b00};
      for (int i = 0; i < got_q.size() && i < v.exp_words; i++)
         chk($sformatf("v%0d_word%0d", idx, i), got_q[i], model(ab + 32'(4 * i)));
   endtask

   initial begin
      int k, loc;
      //      base           len    rdw wrw merr aerr words acks done adr            err
      vt[0] = '{32'h0000_1000, 16'd8,  0, 0, -1, -1,  8,  2, 1, 32'h0000_1020, 1'b0};
      vt[1] = '{32'h0000_2000, 16'd6,  0, 0, -1, -1,  6,  2, 1, 32'h0000_2018, 1'b0};
      vt[2] = '{32'h0000_3003, 16'd1,  1, 2, -1, -1,  1,  1, 1, 32'h0000_3004, 1'b0};
      vt[3] = '{32'hFFFF_FFF0, 16'd37, 5, 5, -1, -1, 37, 10, 1, 32'h0000_0084, 1'b0};
      vt[4] = '{32'h0000_4000, 16'd0,  0, 0, -1, -1,  0,  0, 1, 32'h0000_4000, 1'b0};
      vt[5] = '{32'h0000_1000, 16'd8,  0, 0,  2, -1,  0,  0, 0, 32'h0000_1008, 1'b1};
      vt[6] = '{32'h0000_1000, 16'd4,  2, 0, -1, -1,  4,  1, 1, 32'h0000_1010, 1'b0};
      vt[7] = '{32'h0000_8000, 16'd8,  1, 1, -1,  5,  5,  1, 0, 32'h0000_8020, 1'b1};

      rst_i = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_loop = 1'b0;
      cfg_base = 32'd0; cfg_len = 16'd0; dma_req_i = 1'b1;
      clr(0, 0, -1, -1);
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_memcyc", {31'd0, mem_cyc_o}, 32'd0);
      chk("rst_acstb", {31'd0, ac_stb_o}, 32'd0);
      chk("rst_memsel", {28'd0, mem_sel_o}, 32'hf);
      chk("rst_acadr", ac_adr_o, 32'h20);
      chk("rst_memadr", mem_adr_o, 32'd0);
      chk("rst_flags", {29'd0, err_o, done_o, dma_ack_o}, 32'd0);
      rst_i = 1'b0;

      for (int i = 0; i < 8; i++) run(i);

      // Looping buffer: three done pulses, every buffer restarts at base.
      clr(0, 0, -1, -1);
      start_xfer(32'h0000_5000, 16'd4, 1'b1);
      chk("loop_errclr", {31'd0, err_o}, 32'd0);
      k = 0; loc = 0;
      while (loc < 3 && k < 2000) begin
         @(negedge clk);
         if (done_o) loc++;
         k++;
      end
      chk("loop_dones", loc, 32'd3);
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      chk("loop_abort_busy", {31'd0, busy_o}, 32'd0);
      chk("loop_acks", ack_cnt, 32'd3);
      chk("loop_nwords", got_q.size(), 32'd12);
      for (int i = 0; i < got_q.size() && i < 12; i++)
         chk($sformatf("loop_word%0d", i), got_q[i], model(32'h0000_5000 + 32'(4 * (i % 4))));

      // Abort during a write beat that is acked in the same cycle.
      clr(0, 0, -1, -1);
      start_xfer(32'h0000_9000, 16'd8, 1'b0);
      k = 0;
      while (!ac_stb_o && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reach_wr", {31'd0, ac_stb_o}, 32'd1);
      cfg_abort = 1'b1;
      @(negedge clk);
      cfg_abort = 1'b0;
      chk("abort_acstb", {31'd0, ac_stb_o}, 32'd0);
      chk("abort_busy", {31'd0, busy_o}, 32'd0);
      repeat (5) @(negedge clk);
      chk("abort_noack", ack_cnt, 32'd0);
      chk("abort_memcyc", {31'd0, mem_cyc_o}, 32'd0);

      // Asynchronous reset mid-read: bus drops without waiting for a clock.
      clr(3, 0, -1, -1);
      start_xfer(32'h0000_A000, 16'd8, 1'b0);
      k = 0;
      while (!mem_stb_o && k < 100) begin
         @(negedge clk);
         k++;
      end
      #2 rst_i = 1'b1;
      #1;
      chk("arst_memcyc", {31'd0, mem_cyc_o}, 32'd0);
      chk("arst_busy", {31'd0, busy_o}, 32'd0);
      @(negedge clk);
      rst_i = 1'b0;
      repeat (6) @(negedge clk);
      chk("arst_noack", ack_cnt, 32'd0);

      // Start while busy is ignored.
      clr(1, 1, -1, -1);
      start_xfer(32'h0000_6000, 16'd8, 1'b0);
      repeat (3) @(negedge clk);
      cfg_base = 32'h0000_7000; cfg_len = 16'd2; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      k = 0;
      while (busy_o && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("sib_adr", mem_adr_o, 32'h0000_6020);
      chk("sib_acks", ack_cnt, 32'd2);
      chk("sib_nwords", got_q.size(), 32'd8);
      if (got_q.size() == 8) chk("sib_last", got_q[7], model(32'h0000_601C));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
